// File: rtl/multi_param_if.sv
// Start/valid handshake bundle for the multi_param sequential multiplier.
// The requester drives the master side; the multiplier is the slave.
interface multi_param_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     mlier;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   prodt;
  logic                 valid;
  logic                 busy;

  modport master (
    output start, signed_mode, mlier, mcand,
    input  prodt, valid, busy
  );

  modport slave (
    input  start, signed_mode, mlier, mcand,
    output prodt, valid, busy
  );
endinterface

// File: rtl/multi_param.sv
// Sequential shift-add multiplier retiring BPC multiplier bits per cycle on
// unsigned magnitudes; the sign is reapplied once, when the result is published.
module multi_param #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic          clock,
  input  logic          reset,
  multi_param_if.slave  bus
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e               state_q, state_d;
  logic                 start_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     mcand_mag_q, mcand_mag_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   prodt_q, prodt_d;
  logic                 valid_q, valid_d;

  logic [WIDTH-1:0]     mlier_mag;
  logic [WIDTH-1:0]     mcand_mag;
  logic                 launch;
  logic [WIDTH+BPC-1:0] sum;
  logic [2*WIDTH-1:0]   shifted;
  logic [2*WIDTH-1:0]   mag;

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign mlier_mag = (bus.signed_mode && bus.mlier[WIDTH-1]) ? -bus.mlier : bus.mlier;
  assign mcand_mag = (bus.signed_mode && bus.mcand[WIDTH-1]) ? -bus.mcand : bus.mcand;
  assign launch    = bus.start && !start_q && (state_q == IDLE);

  // hi stays below 2^WIDTH, so hi + mcand*digit always fits in WIDTH+BPC bits.
  assign sum = {{BPC{1'b0}}, hi_q}
             + ({{BPC{1'b0}}, mcand_mag_q} * {{WIDTH{1'b0}}, lo_q[BPC-1:0]});

  generate
    if (BPC < WIDTH) begin : g_shift
      assign shifted = {sum, lo_q[WIDTH-1:BPC]};
    end else begin : g_shift_full
      assign shifted = sum;
    end
  endgenerate

  assign mag = {hi_q, lo_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mcand_mag_d = mcand_mag_q;
    neg_d       = neg_q;
    prodt_d     = prodt_q;
    valid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d     = CALC;
          cnt_d       = CW'(N);
          hi_d        = '0;
          lo_d        = mlier_mag;
          mcand_mag_d = mcand_mag;
          neg_d       = bus.signed_mode & (bus.mlier[WIDTH-1] ^ bus.mcand[WIDTH-1]);
        end
      end
      CALC: begin
        hi_d  = shifted[2*WIDTH-1:WIDTH];
        lo_d  = shifted[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        prodt_d = neg_q ? -mag : mag;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mcand_mag_q <= '0;
      neg_q       <= 1'b0;
      prodt_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= bus.start;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mcand_mag_q <= mcand_mag_d;
      neg_q       <= neg_d;
      prodt_q     <= prodt_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.prodt = prodt_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_multi_param.sv
// Directed and table-driven checks of multi_param (WIDTH=32, BPC=1) plus a
// randomised sweep over WIDTH in {8,32} and BPC in {1,2,4}.
module tb_multi_param;
  localparam int W = 32;
  localparam int N = 32;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  bit   sweep_go;
  int   sweep_fin;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  multi_param_if #(.WIDTH(W)) mif ();
  multi_param #(.WIDTH(W), .BPC(1)) dut (.clock(clock), .reset(reset), .bus(mif));

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch edge is the next rising edge; operands are scrambled right after it.
  task automatic launch(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    mif.signed_mode = sm;
    mif.mlier       = a;
    mif.mcand       = b;
    mif.start       = 1'b1;
    tick();
    mif.start       = 1'b0;
    mif.mlier       = $urandom;
    mif.mcand       = $urandom;
    mif.signed_mode = ~sm;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (mif.valid) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic        sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [12];

  // Sweep instances: configs 0..2 are WIDTH=8, 3..5 WIDTH=32, BPC cycling 1,2,4.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : gen_sweep
      localparam int SW = (gi < 3) ? 8 : 32;
      localparam int SB = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 2 : 4);
      localparam int NS = SW / SB;

      multi_param_if #(.WIDTH(SW)) sif ();
      multi_param #(.WIDTH(SW), .BPC(SB)) sdut (.clock(clock), .reset(reset), .bus(sif));

      initial begin
        logic [SW-1:0]   a, b;
        logic [2*SW-1:0] ea, eb, ex;
        logic            sm;
        int              lat;
        sif.start       = 1'b0;
        sif.signed_mode = 1'b0;
        sif.mlier       = '0;
        sif.mcand       = '0;
        wait (sweep_go);
        tick();
        for (int i = 0; i < 40; i++) begin
          sm = i[0];
          a  = SW'($urandom);
          b  = SW'($urandom);
          if (i < 2) begin
            a = {1'b1, {(SW-1){1'b0}}};
            b = {1'b1, {(SW-1){1'b0}}};
          end else if (i < 4) begin
            a = '1;
            b = {1'b1, {(SW-1){1'b0}}};
          end
          ea = sm ? {{SW{a[SW-1]}}, a} : {{SW{1'b0}}, a};
          eb = sm ? {{SW{b[SW-1]}}, b} : {{SW{1'b0}}, b};
          ex = ea * eb;
          sif.signed_mode = sm;
          sif.mlier       = a;
          sif.mcand       = b;
          sif.start       = 1'b1;
          tick();
          sif.start = 1'b0;
          sif.mlier = ~a;
          sif.mcand = ~b;
          lat = -1;
          for (int k = 1; k <= NS + 10; k++) begin
            tick();
            if (sif.valid) begin
              lat = k;
              break;
            end
          end
          chk("sweep_latency", 64'(lat), 64'(NS + 1));
          chk("sweep_prodt", 64'(sif.prodt), 64'(ex));
          $display("sweep W=%0d BPC=%0d op %0d sm=%0d 0x%h x 0x%h -> 0x%h lat %0d",
                   SW, SB, i, sm, a, b, sif.prodt, lat);
        end
        sweep_fin++;
      end
    end
  endgenerate

  initial begin
    int          lat;
    int          vcount;
    int          vk [2];
    logic [63:0] vp [2];
    logic        busy_seen;

    checks    = 0;
    errors    = 0;
    sweep_go  = 1'b0;
    sweep_fin = 0;

    vecs[0]  = '{1'b1, 32'h00000003, 32'hFFFFFFFB, 64'hFFFFFFFF_FFFFFFF1};
    vecs[1]  = '{1'b0, 32'h00000003, 32'hFFFFFFFB, 64'h00000002_FFFFFFF1};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[3]  = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000};
    vecs[4]  = '{1'b1, 32'h00000000, 32'h7FFFFFFF, 64'h00000000_00000000};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[6]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    vecs[7]  = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
    vecs[8]  = '{1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[9]  = '{1'b1, 32'h12345678, 32'hFFFFFFFF, 64'hFFFFFFFF_EDCBA988};
    vecs[10] = '{1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000};
    vecs[11] = '{1'b1, 32'hFFFFFFFE, 32'h7FFFFFFF, 64'hFFFFFFFF_00000002};

    reset           = 1'b0;
    mif.start       = 1'b0;
    mif.signed_mode = 1'b0;
    mif.mlier       = '0;
    mif.mcand       = '0;
    repeat (3) tick();
    chk("reset_prodt", mif.prodt, 64'h0);
    chk("reset_valid", 64'(mif.valid), 64'h0);
    chk("reset_busy", 64'(mif.busy), 64'h0);

    // start already high when reset releases launches on the first edge
    mif.mlier = 32'd6;
    mif.mcand = 32'd7;
    mif.start = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    mif.start = 1'b0;
    chk("release_busy", 64'(mif.busy), 64'h1);
    wait_valid(lat);
    chk("release_latency", 64'(lat), 64'(N + 1));
    chk("release_prodt", mif.prodt, 64'd42);
    $display("release launch: prodt=0x%h lat %0d", mif.prodt, lat);
    tick();

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].sm, vecs[i].a, vecs[i].b);
      chk("vec_busy", 64'(mif.busy), 64'h1);
      wait_valid(lat);
      chk("vec_latency", 64'(lat), 64'(N + 1));
      chk("vec_prodt", mif.prodt, vecs[i].exp);
      $display("vec %0d sm=%0d 0x%h x 0x%h -> 0x%h lat %0d",
               i, vecs[i].sm, vecs[i].a, vecs[i].b, mif.prodt, lat);
      tick();
      chk("vec_valid_pulse", 64'(mif.valid), 64'h0);
      chk("vec_prodt_hold", mif.prodt, vecs[i].exp);
      chk("vec_idle", 64'(mif.busy), 64'h0);
    end

    // start held high for 40+ cycles launches once
    mif.signed_mode = 1'b0;
    mif.mlier       = 32'd5;
    mif.mcand       = 32'd7;
    mif.start       = 1'b1;
    vcount = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (mif.valid) vcount++;
    end
    mif.start = 1'b0;
    chk("hold_start_valids", 64'(vcount), 64'd1);
    chk("hold_start_prodt", mif.prodt, 64'd35);
    $display("held start: %0d valid pulse(s), prodt=0x%h", vcount, mif.prodt);
    tick();

    // a rising start while busy is dropped, not queued
    launch(1'b0, 32'd11, 32'd13);
    vcount = 0;
    for (int k = 1; k <= 50; k++) begin
      if (k == 5) begin
        mif.mlier = 32'd9;
        mif.mcand = 32'd9;
        mif.start = 1'b1;
      end
      if (k == 7) mif.start = 1'b0;
      tick();
      if (mif.valid) vcount++;
    end
    chk("busy_start_valids", 64'(vcount), 64'd1);
    chk("busy_start_prodt", mif.prodt, 64'd143);
    $display("start while busy: %0d valid pulse(s), prodt=0x%h", vcount, mif.prodt);

    // a rising start landing on the DONE edge is ignored
    launch(1'b1, 32'hFFFFFFFE, 32'd3);
    vcount    = 0;
    busy_seen = 1'b1;
    for (int k = 1; k <= N + 8; k++) begin
      if (k == N + 1) begin
        mif.mlier = 32'd2;
        mif.mcand = 32'd2;
        mif.start = 1'b1;
      end
      if (k == N + 4) mif.start = 1'b0;
      tick();
      if (mif.valid) vcount++;
      if (k == N + 2) busy_seen = mif.busy;
    end
    chk("done_edge_valids", 64'(vcount), 64'd1);
    chk("done_edge_busy", 64'(busy_seen), 64'h0);
    chk("done_edge_prodt", mif.prodt, 64'hFFFFFFFF_FFFFFFFA);
    $display("start at done edge: %0d valid pulse(s), prodt=0x%h", vcount, mif.prodt);

    // back-to-back launches at minimum spacing
    launch(1'b0, 32'h00001000, 32'h00000003);
    vcount = 0;
    vk[0] = -1; vk[1] = -1;
    vp[0] = '0; vp[1] = '0;
    for (int k = 1; k <= 2 * N + 8; k++) begin
      if (k == N + 2) begin
        mif.signed_mode = 1'b1;
        mif.mlier       = 32'hFFFFFFFF;
        mif.mcand       = 32'h00000005;
        mif.start       = 1'b1;
      end
      if (k == N + 3) begin
        mif.start = 1'b0;
        mif.mlier = $urandom;
        mif.mcand = $urandom;
      end
      tick();
      if (mif.valid) begin
        if (vcount < 2) begin
          vk[vcount] = k;
          vp[vcount] = mif.prodt;
        end
        vcount++;
      end
    end
    chk("b2b_valids", 64'(vcount), 64'd2);
    chk("b2b_first_at", 64'(vk[0]), 64'(N + 1));
    chk("b2b_second_at", 64'(vk[1]), 64'(2 * N + 3));
    chk("b2b_first_prodt", vp[0], 64'h3000);
    chk("b2b_second_prodt", vp[1], 64'hFFFFFFFF_FFFFFFFB);
    $display("back-to-back: valids at %0d and %0d, prodt 0x%h then 0x%h", vk[0], vk[1], vp[0], vp[1]);

    // reset at E10 of an operation discards it
    launch(1'b0, 32'h00001234, 32'h00005678);
    repeat (9) tick();
    reset = 1'b0;
    tick();
    chk("midreset_busy", 64'(mif.busy), 64'h0);
    chk("midreset_prodt", mif.prodt, 64'h0);
    chk("midreset_valid", 64'(mif.valid), 64'h0);
    reset  = 1'b1;
    vcount = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (mif.valid) vcount++;
    end
    chk("midreset_no_valid", 64'(vcount), 64'd0);
    chk("midreset_prodt_after", mif.prodt, 64'h0);
    $display("mid-op reset: %0d valid pulse(s), prodt=0x%h", vcount, mif.prodt);

    sweep_go = 1'b1;
    for (int k = 0; k < 8000 && sweep_fin < 6; k++) @(posedge clock);
    chk("sweep_complete", 64'(sweep_fin), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_param.md
# multi_param

Parametrised sequential integer multiplier, the next generation of the fixed-latency `multi` block. Computes a `2*WIDTH`-bit product of two `WIDTH`-bit operands over a fixed, parameter-determined number of cycles. Signedness is selectable per operation, and the number of multiplier bits retired per cycle is configurable. It serves datapaths that need a small-area multiplier with a start/valid handshake and deterministic latency.

## Interface
- `WIDTH`, 32: operand width in bits. Must be even and ≥ 4.
- `BPC`, 1: multiplier bits retired per cycle. Legal values are 1, 2 and 4; `WIDTH % BPC == 0`.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low. `reset==0` at a rising edge resets the block.
- `start` in 1: launch request. Only a 0→1 transition is a launch (see Operation).
- `signed_mode` in 1: 1 = two's-complement operands and product; 0 = unsigned. Sampled at launch.
- `mlier` in WIDTH: multiplier. Sampled at launch only.
- `mcand` in WIDTH: multiplicand. Sampled at launch only.
- `prodt` out 2*WIDTH: product. Holds the last result until the next `valid`.
- `valid` out 1: one-cycle pulse when `prodt` is updated.
- `busy` out 1: high while an operation is in flight.

## Operation
- Let N = WIDTH/BPC.
- States:
  - IDLE: `busy=0`.
  - CALC: `busy=1`, counter runs N down to 1.
  - DONE: `busy=1`, `valid=1`, one cycle only. Always returns to IDLE.
- Launch: `start` is registered as `start_q`. A launch occurs at an edge where `start==1 && start_q==0` and the state is IDLE.
  - `start` held high for many cycles produces exactly one launch.
  - A rising `start` seen outside IDLE is ignored and not queued.
- At the launch edge the block latches:
  - `signed_mode`;
  - the magnitudes of `mlier` and `mcand`, each WIDTH-bit unsigned (in signed mode a negative operand is two's-complement negated; −2^(WIDTH−1) yields magnitude 2^(WIDTH−1), which fits);
  - the product sign, `neg = signed_mode & (mlier[MSB] ^ mcand[MSB])`.
- Each CALC cycle adds `mcand_mag * mlier_mag[BPC-1:0]` into the upper partial accumulator, then shifts by BPC. No Booth recoding is used; the partial products are unsigned.
- On the transition CALC→DONE, `prodt` is loaded with the 2*WIDTH-bit magnitude, negated when `neg` is set. The result is exact for every operand pair, with no overflow or saturation.
- Operand inputs may change freely after the launch edge without affecting the result.
- Reset values: `prodt=0`, `valid=0`, `busy=0`, state IDLE, `start_q=0`.
  - The reset value `start_q=0` means `start` already high when reset releases counts as a launch on the first edge after release.
- Reset mid-operation discards the operation entirely: no `valid` pulse and `prodt` returns to 0.

## Timing
- Launch edge is E0. `busy` is high from after E0 through the cycle that ends at E(N+1).
- `valid` is high for exactly one cycle, after edge E(N+1). `prodt` is valid at the same moment.
  - WIDTH=32, BPC=1: valid after E33.
  - WIDTH=32, BPC=4: valid after E9.
- Minimum launch-to-launch spacing is N+2 edges. The next launch may be at E(N+2), provided `start` was low at E(N+1) (a rising edge is required).
- `start` 0→1 landing exactly at E(N+1), while in DONE, is ignored. The requester must drop `start` and raise it again.
- `prodt` is stable between `valid` pulses and never shows intermediate values.

## Test plan
- WIDTH=32, BPC=1, `signed_mode=1`, 0x00000003 × 0xFFFFFFFB → `prodt`=0xFFFFFFFFFFFFFFF1 with `valid` after E33. Then `signed_mode=0` on the same operands → 0x00000002FFFFFFF1.
- Corner operands, signed:
  - 0x80000000 × 0x80000000 → 0x4000000000000000;
  - 0x80000000 × 0x00000001 → 0xFFFFFFFF80000000;
  - 0 × 0x7FFFFFFF → 0.
- `start` held high for 40 cycles with 5 ms... correction: `start` held high for 40 cycles → exactly one `valid` pulse. A second 0→1 while `busy` → no extra `valid`, and `prodt` keeps the first result.
- `reset` driven low at E10 of an operation → `busy=0`, `prodt=0` next cycle, and no `valid` ever for that operation.
- Sweep over BPC∈{1,2,4}, WIDTH∈{8,32}, 20 random operand pairs each, both modes, compared against a reference multiply → all match, with the valid latency equal to N+1 every time.
- Back-to-back launches at minimum spacing (launch at E0 and E(N+2)) → two `valid` pulses N+2 cycles apart with correct products.
